fp_adder_pipe: RTL
==================

// Module: fp_adder_pipe
// PURPOSE
// Pipelined, parametrised IEEE-754 floating-point adder/subtractor; successor to the combinational fp_adder.
// Four-stage pipeline, valid/ready handshake, runtime add/sub select, exception flags, full subnormal support.
// Sits between operand producers and result consumers in the FP datapath; one operation accepted per cycle when unstalled.
// PARAMETERS
// EXP_W   8    exponent field width (bias = 2**(EXP_W-1)-1)
// MAN_W   23   stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
// PORTS
// clk        in   1   single clock; all state updates on rising edge
// rst        in   1   synchronous, active-high reset
// in_valid   in   1   operands a, b, op valid this cycle
// in_ready   out  1   pipeline can accept; transfer when in_valid && in_ready
// a          in   W   operand A (IEEE format: sign|exp|frac)
// b          in   W   operand B
// op         in   1   0: a+b, 1: a-b (b sign inverted before stage 1)
// out_valid  out  1   s and flags valid
// out_ready  in   1   consumer accepts; transfer when out_valid && out_ready
// s          out  W   rounded result
// flag_inv   out  1   invalid: inf-inf (effective), or any sNaN/NaN input
// flag_ovf   out  1   finite operands, rounded result overflowed to inf
// flag_inx   out  1   result inexact (guard|round|sticky nonzero or overflow)
// BEHAVIOUR
// - Reset: all stage valid bits, out_valid, s, flags = 0; in_ready = 1 from first cycle after reset.
// - Pipeline: S1 unpack/classify (zero, sub, inf, NaN), effective op, swap so |A|>=|B|;
//   S2 align B right by exp diff, shift saturates at MAN_W+3, shifted-out bits OR into sticky;
//   S3 MAN_W+4-bit add/sub of hidden|frac|G|R|S, leading-zero count;
//   S4 normalise, round-to-nearest-even, exponent adjust, pack, special-case override.
// - Latency: exactly 4 cycles from input transfer to out_valid when never stalled. Throughput 1/cycle.
// - Stall: stall = out_valid && !out_ready; whole pipe holds, in_ready = !stall (combinational).
//   Bubbles do not compress during stall; results leave strictly in input order, no drop/duplication.
// - Subnormals: exp field 0 => hidden bit 0, effective exponent 1; results below min normal packed as subnormal, exp=0.
// - Normalisation left shift limited so exponent never goes below 1 (gradual underflow).
// - Carry out of add: shift right 1, LSB into sticky, exp+1. Rounding carry into hidden overflow: exp+1, frac=0.
// - Overflow: biased exp >= 2**EXP_W-1 after rounding => s = sign|all-ones exp|0, flag_ovf=1, flag_inx=1.
// - Exact zero from effective subtraction of equal magnitudes: +0 (RNE). (+0)+(+0)=+0, (-0)+(-0)=-0, (+0)+(-0)=+0.
// - inf +/- finite = that inf, no flags. inf - inf (effective) = canonical qNaN, flag_inv=1.
// - Any NaN input => canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0), flag_inv=1.
// - Flags are per-result, aligned with s, not sticky across results.
// - Reset mid-operation: synchronous rst in any cycle flushes all in-flight ops; out_valid=0 next cycle; no partial result emitted.
// - in_valid while !in_ready: operand not captured; producer holds it.
// TESTING (default EXP_W=8, MAN_W=23)
// 1. a=3F800000, b=40000000, op=0 -> s=40400000 exactly 4 cycles later, flags 000.
// 2. a=3F800000, b=3F800000, op=1 -> s=00000000; a=00000001, b=00000001, op=0 -> s=00000002, flags 000.
// 3. a=7F7FFFFF, b=7F7FFFFF -> s=7F800000, flag_ovf=1, flag_inx=1; a=7F800000, b=7F800000, op=1 -> s=7FC00000, flag_inv=1.
// 4. a=3F800000, b=33800000 (2^-24 tie) -> s=3F800000, flag_inx=1 (ties-to-even); b=33800001 -> s=3F800001.
// 5. Stream 10 ops back-to-back, hold out_ready=0 cycles 3..7 -> in_ready low exactly those stall cycles, all 10 results in order, none lost.
// 6. Assert rst with 3 ops in flight -> out_valid=0 next cycle, no stale result after release; then 1e6 random a,b,op vs shortreal model, 0 mismatches excluding NaN payloads.

Source files
------------

// File: rtl/fp_adder_if.sv
// Operand/result handshake bundle for fp_adder_pipe.
//   in_valid/in_ready   : operand transfer when both high
//   a, b, op            : operands (sign|exp|frac) and add(0)/sub(1) select
//   out_valid/out_ready : result transfer when both high
//   s, flag_*           : rounded result and per-result exception flags
// master: producer/consumer side; slave: the adder.
interface fp_adder_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         flag_inv;
    logic         flag_ovf;
    logic         flag_inx;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, s, flag_inv, flag_ovf, flag_inx
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, s, flag_inv, flag_ovf, flag_inx
    );
endinterface

// File: rtl/fp_adder_pipe.sv
// Four-stage pipelined IEEE-754 adder/subtractor, round-to-nearest-even, with
// subnormal support and invalid/overflow/inexact flags.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, flushes every in-flight operation
//   bus : fp_adder_if slave (operand handshake in, result handshake out)
// Stages: S1 unpack/classify/swap, S2 align, S3 add + leading-zero count,
// S4 normalise/round/pack. The whole pipe freezes while the output is stalled.
module fp_adder_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic      clk,
    input logic      rst,
    fp_adder_if.slave bus
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned XW  = MAN_W + 4;          // hidden|frac|G|R|S
    localparam int unsigned SHW = $clog2(XW + 1);

    localparam logic [EXP_W-1:0] ExpOnes = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNan    = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic sign;  // sign of the larger magnitude operand
        logic sub;   // effective subtraction
        logic nan;   // result is canonical qNaN
        logic inf;   // result is infinity (sign = sign field)
    } ctl_t;

    logic stall;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    // ---------------- S1: unpack, classify, swap ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sa, sb, a_big, a_nan, b_nan, a_inf, b_inf;

    assign sa = bus.a[W-1];
    assign sb = bus.b[W-1] ^ bus.op;
    assign ea = bus.a[W-2 -: EXP_W];
    assign eb = bus.b[W-2 -: EXP_W];
    assign fa = bus.a[MAN_W-1:0];
    assign fb = bus.b[MAN_W-1:0];

    assign a_nan = (ea == ExpOnes) && (fa != '0);
    assign b_nan = (eb == ExpOnes) && (fb != '0);
    assign a_inf = (ea == ExpOnes) && (fa == '0);
    assign b_inf = (eb == ExpOnes) && (fb == '0);
    assign a_big = {ea, fa} >= {eb, fb};

    // Subnormals use exponent 1 with a zero hidden bit.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

    ctl_t s1_ctl_d;
    always_comb begin
        s1_ctl_d.sign = a_big ? sa : sb;
        s1_ctl_d.sub  = sa ^ sb;
        s1_ctl_d.nan  = a_nan || b_nan || (a_inf && b_inf && (sa ^ sb));
        s1_ctl_d.inf  = a_inf || b_inf;
    end

    logic             s1_valid_q;
    ctl_t             s1_ctl_q;
    logic [EXP_W-1:0] s1_exp_big_q, s1_exp_small_q;
    logic [MAN_W:0]   s1_man_big_q, s1_man_small_q;

    // ---------------- S2: align smaller operand ----------------
    logic [EXP_W-1:0] diff;
    logic [SHW-1:0]   sh;
    logic [XW-1:0]    small_ext, small_shr, lost_mask, s2_small_d;

    always_comb begin
        diff      = s1_exp_big_q - s1_exp_small_q;
        sh        = (32'(diff) > XW - 1) ? SHW'(XW - 1) : SHW'(diff);
        small_ext = {s1_man_small_q, 3'b000};
        lost_mask = ~({XW{1'b1}} << sh);
        small_shr = small_ext >> sh;
        // Everything shifted past the sticky position collapses into it.
        s2_small_d = {small_shr[XW-1:1], small_shr[0] | (|(small_ext & lost_mask))};
    end

    logic             s2_valid_q;
    ctl_t             s2_ctl_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [MAN_W:0]   s2_man_big_q;
    logic [XW-1:0]    s2_small_q;

    // ---------------- S3: add/sub, leading-zero count ----------------
    logic [XW:0]    big_ext, sum_d;
    logic [SHW-1:0] lzc_d;

    always_comb begin
        big_ext = {1'b0, s2_man_big_q, 3'b000};
        // Swap guarantees big >= small, so subtraction never goes negative.
        sum_d = s2_ctl_q.sub ? (big_ext - {1'b0, s2_small_q})
                             : (big_ext + {1'b0, s2_small_q});
        lzc_d = SHW'(XW);
        for (int i = 0; i < int'(XW); i++) begin
            if (sum_d[i]) lzc_d = SHW'(int'(XW) - 1 - i);
        end
    end

    logic             s3_valid_q;
    ctl_t             s3_ctl_q;
    logic [EXP_W-1:0] s3_exp_q;
    logic [XW:0]      s3_sum_q;
    logic [SHW-1:0]   s3_lzc_q;

    // ---------------- S4: normalise, round, pack ----------------
    logic [EXP_W:0]   exp_x, limit, e_norm, exp_field;
    logic [SHW-1:0]   lshift;
    logic [XW-1:0]    mant;
    logic [MAN_W:0]   kept;
    logic [MAN_W+1:0] rounded;
    logic [MAN_W-1:0] frac;
    logic             g, r, st, round_up, inexact, is_zero, ovf;
    logic [W-1:0]     s_d;
    logic             inv_d, ovf_d, inx_d;

    always_comb begin
        exp_x  = {1'b0, s3_exp_q};
        limit  = exp_x - (EXP_W+1)'(1);
        lshift = '0;
        mant   = '0;
        e_norm = exp_x;
        if (s3_sum_q[XW]) begin
            // Carry out: shift right one, dropped bit joins sticky.
            mant   = {s3_sum_q[XW:2], s3_sum_q[1] | s3_sum_q[0]};
            e_norm = exp_x + (EXP_W+1)'(1);
        end else begin
            // Left shift is capped so the exponent stops at 1 (gradual underflow).
            lshift = (32'(s3_lzc_q) <= 32'(limit)) ? s3_lzc_q : SHW'(limit);
            mant   = s3_sum_q[XW-1:0] << lshift;
            e_norm = exp_x - (EXP_W+1)'(lshift);
        end

        kept     = mant[XW-1:3];
        g        = mant[2];
        r        = mant[1];
        st       = mant[0];
        inexact  = g | r | st;
        round_up = g & (r | st | kept[0]);
        rounded  = {1'b0, kept} + (MAN_W+2)'(round_up);

        exp_field = '0;
        frac      = rounded[MAN_W-1:0];
        if (rounded[MAN_W+1]) begin
            exp_field = e_norm + (EXP_W+1)'(1);
            frac      = '0;
        end else if (rounded[MAN_W]) begin
            exp_field = e_norm;
        end

        is_zero = (s3_sum_q == '0);
        ovf     = exp_field >= {1'b0, ExpOnes};

        s_d   = {s3_ctl_q.sign, exp_field[EXP_W-1:0], frac};
        inv_d = 1'b0;
        ovf_d = 1'b0;
        inx_d = inexact;
        if (s3_ctl_q.nan) begin
            s_d   = QNan;
            inv_d = 1'b1;
            inx_d = 1'b0;
        end else if (s3_ctl_q.inf) begin
            s_d   = {s3_ctl_q.sign, ExpOnes, {MAN_W{1'b0}}};
            inx_d = 1'b0;
        end else if (is_zero) begin
            // Cancellation gives +0; like-signed zeros keep their sign.
            s_d = {s3_ctl_q.sign & ~s3_ctl_q.sub, {(W-1){1'b0}}};
        end else if (ovf) begin
            s_d   = {s3_ctl_q.sign, ExpOnes, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
            inx_d = 1'b1;
        end
    end

    // ---------------- Pipeline registers ----------------
    logic         out_valid_q;
    logic [W-1:0] s_q;
    logic         inv_q, ovf_q, inx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (!stall) begin
            s1_valid_q  <= bus.in_valid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                s_q   <= s_d;
                inv_q <= inv_d;
                ovf_q <= ovf_d;
                inx_q <= inx_d;
            end
        end
    end

    // Datapath registers need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_ctl_q       <= s1_ctl_d;
            s1_exp_big_q   <= a_big ? eff_exp(ea) : eff_exp(eb);
            s1_exp_small_q <= a_big ? eff_exp(eb) : eff_exp(ea);
            s1_man_big_q   <= a_big ? {|ea, fa} : {|eb, fb};
            s1_man_small_q <= a_big ? {|eb, fb} : {|ea, fa};

            s2_ctl_q     <= s1_ctl_q;
            s2_exp_q     <= s1_exp_big_q;
            s2_man_big_q <= s1_man_big_q;
            s2_small_q   <= s2_small_d;

            s3_ctl_q <= s2_ctl_q;
            s3_exp_q <= s2_exp_q;
            s3_sum_q <= sum_d;
            s3_lzc_q <= lzc_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.flag_inv  = inv_q;
    assign bus.flag_ovf  = ovf_q;
    assign bus.flag_inx  = inx_q;
endmodule
